uart_rx_frame_sampler: RTL and testbench
========================================

Name: uart_rx_frame_sampler

Overview:
Front end of the UART receiver, directly upstream of the parity checker.
- Oversamples the serial line, detects the start bit and majority-votes each bit.
- Deserialises data LSB-first and presents P_DATA plus the sampled parity bit with a one-cycle par_chk_en strobe.
- Consumes the registered par_err result and issues a qualified data_valid, or an error pulse, per frame.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of PRESCALE input

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-low
RX_IN  in  1  serial line, idle high (already synchronised)
PRESCALE  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
PAR_EN  in  1  1 = frame carries a parity bit
par_err  in  1  registered result from the parity checker
sampled_bit  out  1  majority-voted value of the current bit
P_DATA  out  DATA_WIDTH  deserialised data, LSB received first
par_chk_en  out  1  one-cycle strobe; sampled_bit is the parity bit
data_valid  out  1  one-cycle pulse; frame good, P_DATA valid
frame_err  out  1  one-cycle pulse; bad stop bit or parity error
strt_glitch  out  1  one-cycle pulse; start bit sampled high
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: synchronous on RST==0 at a CLK edge.
  - All outputs 0, except sampled_bit=1.
  - State IDLE; counters 0.
  - Reset mid-frame aborts the frame with no pulses.
- Prescale P: latched on start detection and held for the whole frame.
  - Any value other than 8/16/32 is treated as 8.
- Edge counter: edge_cnt counts 0..P-1 per bit.
  - The IDLE cycle that sees RX_IN==0 is edge 0 of the start bit.
- Majority sampling: RX_IN captured at edge_cnt P/2-1, P/2 and P/2+1.
  - 2-of-3 vote registered into sampled_bit; valid from edge P/2+2.
  - This is the decision edge D.
- States:
  - IDLE: RX_IN==0 -> START. Clear P_DATA and the internal stop/parity flags.
  - START: at D, if sampled_bit==1, pulse strt_glitch and go to IDLE. Otherwise at edge P-1 -> DATA with bit_cnt=0.
  - DATA: at D, P_DATA <= {sampled_bit, P_DATA[DW-1:1]}. At edge P-1, bit_cnt++. After bit DATA_WIDTH-1, go to PARITY if PAR_EN, else STOP.
  - PARITY: par_chk_en=1 for exactly the D cycle. At D+1, latch par_err into sticky perr. At edge P-1 -> STOP.
  - STOP: at D, serr = (sampled_bit==0), then go to OUT. The remaining half stop bit is skipped so back-to-back frames are accepted.
  - OUT (1 cycle): if neither perr nor serr, pulse data_valid; otherwise pulse frame_err. Then go to IDLE.
- P_DATA is stable from the last DATA shift until the next start detection, so the parity checker sees constant data.
- With PAR_EN=0, par_chk_en never asserts and perr stays 0.
- Latency (P=8, PAR_EN=1): start detected at cycle 0 -> data_valid at cycle 87.
- An RX_IN low in the OUT cycle is not detected as a start; detection resumes in IDLE.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, OUT)
  - legal prescale constants 8/16/32
  - DATA_WIDTH default
- One sub-module, uart_rx_data_sampling: edge_cnt-driven 3-sample capture and majority vote producing sampled_bit.
- The FSM, bit counter, shift register and qualification logic stay in the top module.

Test Plan:
- P=8, PAR_EN=1, byte 0xA5, even parity bit 0, checker reports par_err=0 -> par_chk_en at cycle 78, data_valid at cycle 87, P_DATA=0xA5, frame_err=0.
- Same frame with parity bit forced to 1 and checker par_err=1 at cycle 79 -> frame_err pulse at cycle 87, no data_valid.
- P=16, PAR_EN=0, byte 0x3C, stop bit 0 -> frame_err, no par_chk_en ever; stop bit 1 -> data_valid, P_DATA=0x3C.
- RX_IN low for 2 cycles then high (P=8) -> strt_glitch at cycle 6, back to IDLE, busy=0 at cycle 7, no data_valid.
- Single-cycle glitch inside data bit 2 at edge 4 (P=8) -> majority still recovers the bit; P_DATA is correct.
- Two back-to-back frames 0x01 then 0xFF at P=32, plus RST=0 asserted mid-second-frame -> first frame data_valid; after reset all outputs 0, sampled_bit=1, no pulse.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    OUT
  } state_t;

endpackage

// File: rtl/uart_rx_data_sampling.sv
// Three-point capture around mid-bit and 2-of-3 majority vote of the serial line.
module uart_rx_data_sampling
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit
);

  logic [PRESCALE_W-1:0] half;
  logic                  first;
  logic                  second;

  assign half = prescale >> 1;

  // The third sample is voted straight from the line, so the result lands one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first       <= 1'b0;
      second      <= 1'b0;
      sampled_bit <= 1'b1;
    end else if (enable) begin
      if (edge_cnt == half - PRESCALE_W'(1)) first <= rx_in;
      if (edge_cnt == half) second <= rx_in;
      if (edge_cnt == half + PRESCALE_W'(1))
        sampled_bit <= (first & second) | (first & rx_in) | (second & rx_in);
    end
  end

endmodule

// File: rtl/uart_rx_frame_sampler.sv
// UART receive front end: start detection, per-bit sampling, deserialisation and
// frame qualification ahead of the parity checker.
module uart_rx_frame_sampler
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  par_err,
  output logic                  sampled_bit,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  par_chk_en,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  strt_glitch,
  output logic                  busy
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_t                state;
  state_t                next_state;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] p_reg;
  logic [PRESCALE_W-1:0] p_sel;
  logic [PRESCALE_W-1:0] d_edge;
  logic [PRESCALE_W-1:0] last_edge;
  logic [BCW-1:0]        bit_cnt;
  logic                  perr;
  logic                  serr;
  logic                  at_d;
  logic                  at_last;

  // Unsupported ratios fall back to the slowest-to-misread setting of 8.
  assign p_sel = (PRESCALE == PRESCALE_W'(PRESCALE_16) || PRESCALE == PRESCALE_W'(PRESCALE_32))
                 ? PRESCALE : PRESCALE_W'(PRESCALE_8);

  assign d_edge    = (p_reg >> 1) + PRESCALE_W'(2);
  assign last_edge = p_reg - PRESCALE_W'(1);
  assign at_d      = (edge_cnt == d_edge);
  assign at_last   = (edge_cnt == last_edge);

  uart_rx_data_sampling #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampling (
    .clk         (CLK),
    .rst_n       (RST),
    .enable      (busy),
    .rx_in       (RX_IN),
    .edge_cnt    (edge_cnt),
    .prescale    (p_reg),
    .sampled_bit (sampled_bit)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    par_chk_en  = 1'b0;
    data_valid  = 1'b0;
    frame_err   = 1'b0;
    strt_glitch = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:   if (!RX_IN) next_state = START;
      START: begin
        if (at_d && sampled_bit) begin
          strt_glitch = 1'b1;
          next_state  = IDLE;
        end else if (at_last) begin
          next_state = DATA;
        end
      end
      DATA:   if (at_last && bit_cnt == LAST_BIT) next_state = PAR_EN ? PARITY : STOP;
      PARITY: begin
        par_chk_en = at_d;
        if (at_last) next_state = STOP;
      end
      // Leaving at the decision edge skips the back half of the stop bit.
      STOP:   if (at_d) next_state = OUT;
      OUT: begin
        data_valid = !(perr || serr);
        frame_err  = perr || serr;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_cnt <= '0;
      p_reg    <= PRESCALE_W'(PRESCALE_8);
      bit_cnt  <= '0;
      P_DATA   <= '0;
      perr     <= 1'b0;
      serr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          edge_cnt <= '0;
          if (!RX_IN) begin
            edge_cnt <= PRESCALE_W'(1);
            p_reg    <= p_sel;
            bit_cnt  <= '0;
            P_DATA   <= '0;
            perr     <= 1'b0;
            serr     <= 1'b0;
          end
        end
        OUT: edge_cnt <= '0;
        default: begin
          edge_cnt <= at_last ? '0 : edge_cnt + PRESCALE_W'(1);
          if (state == DATA && at_d) P_DATA <= {sampled_bit, P_DATA[DATA_WIDTH-1:1]};
          if (state == DATA && at_last) bit_cnt <= bit_cnt + BCW'(1);
          // The checker answers one cycle after the strobe.
          if (state == PARITY && edge_cnt == d_edge + PRESCALE_W'(1)) perr <= perr | par_err;
          if (state == STOP && at_d) serr <= !sampled_bit;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Directed-frame bench for uart_rx_frame_sampler with a queue-based scoreboard.
module tb_uart_rx_frame_sampler;

  localparam int DW = 8;
  localparam int PW = 6;

  localparam int K_PCHK   = 0;
  localparam int K_VALID  = 1;
  localparam int K_FERR   = 2;
  localparam int K_GLITCH = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] PRESCALE;
  logic          PAR_EN;
  logic          par_err;
  logic          sampled_bit;
  logic [DW-1:0] P_DATA;
  logic          par_chk_en;
  logic          data_valid;
  logic          frame_err;
  logic          strt_glitch;
  logic          busy;

  typedef struct {
    int kind;
    int cyc;
    int data;
  } ev_t;

  ev_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t0;
  logic force_perr = 1'b0;
  logic chk_seen   = 1'b0;

  uart_rx_frame_sampler #(
    .DATA_WIDTH (DW),
    .PRESCALE_W (PW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PRESCALE    (PRESCALE),
    .PAR_EN      (PAR_EN),
    .par_err     (par_err),
    .sampled_bit (sampled_bit),
    .P_DATA      (P_DATA),
    .par_chk_en  (par_chk_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .strt_glitch (strt_glitch),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Stand-in for the registered parity checker: answers one cycle after the strobe.
  initial begin
    par_err = 1'b0;
    forever begin
      @(negedge CLK);
      par_err  = chk_seen;
      chk_seen = par_chk_en && force_perr;
    end
  end

  task automatic push_ev(input int kind, input int at, input int data);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_event(input string name, input int kind, input int data);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s: unexpected pulse at cyc=%0d data=%0h, required none", name, cyc, data);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.data != data) begin
        n_fail++;
        $display("[TB] FAIL %s: got kind=%0d cyc=%0d data=%0h, required kind=%0d cyc=%0d data=%0h",
                 name, kind, cyc, data, e.kind, e.cyc, e.data);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (par_chk_en)  check_event("par_chk_en", K_PCHK, {31'b0, sampled_bit});
      if (data_valid)  check_event("data_valid", K_VALID, {24'b0, P_DATA});
      if (frame_err)   check_event("frame_err", K_FERR, 0);
      if (strt_glitch) check_event("strt_glitch", K_GLITCH, {31'b0, sampled_bit});
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives one frame starting at the current cycle; cut < DW stops after that many data bits.
  task automatic apply_stimulus(input logic [DW-1:0] data, input int p, input logic par_en,
                                input logic par_bit, input logic stop_bit,
                                input int glitch_bit, input int cut);
    RX_IN = 1'b0;
    hold(p);
    for (int i = 0; i < DW; i++) begin
      if (i == cut) return;
      RX_IN = data[i];
      if (i == glitch_bit) begin
        hold(4);
        RX_IN = ~data[i];
        hold(1);
        RX_IN = data[i];
        hold(p - 5);
      end else begin
        hold(p);
      end
    end
    if (par_en) begin
      RX_IN = par_bit;
      hold(p);
    end
    if (stop_bit) begin
      RX_IN = 1'b1;
      hold(p);
    end else begin
      RX_IN = 1'b0;
      hold(p / 2 + 4);
      RX_IN = 1'b1;
      hold(p - p / 2 - 4);
    end
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge CLK);
    check_output({tag, "_sampled_bit"}, {31'b0, sampled_bit}, 1);
    check_output({tag, "_p_data"}, {24'b0, P_DATA}, 0);
    check_output({tag, "_flags"}, {27'b0, par_chk_en, data_valid, frame_err, strt_glitch, busy}, 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PRESCALE = PW'(8);
    hold(3);
    check_reset_state("reset");
    RST = 1'b1;
    hold(3);

    PRESCALE = PW'(8);
    PAR_EN   = 1'b1;
    t0 = cyc;
    push_ev(K_PCHK, t0 + 78, 0);
    push_ev(K_VALID, t0 + 87, 32'hA5);
    apply_stimulus(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, DW);

    force_perr = 1'b1;
    t0 = cyc;
    push_ev(K_PCHK, t0 + 78, 1);
    push_ev(K_FERR, t0 + 87, 0);
    apply_stimulus(8'hA5, 8, 1'b1, 1'b1, 1'b1, -1, DW);
    hold(4);
    force_perr = 1'b0;

    PRESCALE = PW'(16);
    PAR_EN   = 1'b0;
    t0 = cyc;
    push_ev(K_FERR, t0 + 155, 0);
    apply_stimulus(8'h3C, 16, 1'b0, 1'b0, 1'b0, -1, DW);
    t0 = cyc;
    push_ev(K_VALID, t0 + 155, 32'h3C);
    apply_stimulus(8'h3C, 16, 1'b0, 1'b0, 1'b1, -1, DW);
    hold(3);

    PRESCALE = PW'(8);
    t0 = cyc;
    push_ev(K_GLITCH, t0 + 6, 1);
    RX_IN = 1'b0;
    hold(2);
    RX_IN = 1'b1;
    hold(5);
    @(negedge CLK);
    check_output("glitch_busy", {31'b0, busy}, 0);
    @(posedge CLK);
    #1;
    hold(2);

    t0 = cyc;
    push_ev(K_VALID, t0 + 79, 32'h5A);
    apply_stimulus(8'h5A, 8, 1'b0, 1'b0, 1'b1, 2, DW);
    hold(2);

    PRESCALE = PW'(20);
    t0 = cyc;
    push_ev(K_VALID, t0 + 79, 32'h96);
    apply_stimulus(8'h96, 8, 1'b0, 1'b0, 1'b1, -1, DW);
    hold(2);

    PRESCALE = PW'(32);
    t0 = cyc;
    push_ev(K_VALID, t0 + 307, 32'h01);
    apply_stimulus(8'h01, 32, 1'b0, 1'b0, 1'b1, -1, DW);
    apply_stimulus(8'hFF, 32, 1'b0, 1'b0, 1'b1, -1, 3);
    check_output("midframe_busy", {31'b0, busy}, 1);
    RST   = 1'b0;
    RX_IN = 1'b1;
    hold(2);
    check_reset_state("midreset");
    RST = 1'b1;
    hold(200);

    PRESCALE = PW'(8);
    PAR_EN   = 1'b1;
    t0 = cyc;
    push_ev(K_PCHK, t0 + 78, 0);
    push_ev(K_VALID, t0 + 87, 32'hC3);
    apply_stimulus(8'hC3, 8, 1'b1, 1'b0, 1'b1, -1, DW);
    hold(20);

    check_output("scoreboard_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
